// File: rtl/pdm_sample_feeder.sv
// pdm_sample_feeder: small sample FIFO that a down-counting divider paces out.
// One sample is popped per period and presented to the PDM modulator with a
// one-cycle write strobe. The block also reports the FIFO level and a sticky
// underrun flag.
module pdm_sample_feeder #(
  parameter int DEPTH = 8,
  parameter int DIV_W = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [4:0]              wr_data_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic                    enable_i,
  input  logic [DIV_W-1:0]        div_i,
  input  logic                    clr_underrun_i,
  output logic [4:0]              sample_out_o,
  output logic                    sample_we_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    underrun_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [4:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [4:0]       sample_q, sample_d;
  logic             we_q, we_d;
  logic             underrun_q, underrun_d;

  logic empty, full, tick, push, pop;

  // Next-state logic: divider tick, FIFO push/pop and output updates.
  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == FULL_LVL);
    tick  = enable_i && (cnt_q == '0);
    push  = wr_valid_i && !full;
    // A push into an empty FIFO is not visible to a same-cycle tick.
    pop   = tick && !empty;

    // Disabled: keep the counter primed with the period so the first tick
    // lands div+1 cycles after enable rises. A new div only lands on reload.
    if (!enable_i || tick) begin
      cnt_d = div_i;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);

    sample_d = pop ? mem_q[rd_ptr_q] : sample_q;
    we_d     = pop;

    // A new underrun wins over a same-cycle clear.
    if (tick && empty) begin
      underrun_d = 1'b1;
    end else if (clr_underrun_i) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      sample_q   <= 5'h00;
      we_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      sample_q   <= sample_d;
      we_q       <= we_d;
      underrun_q <= underrun_d;
    end
  end

  // Sample storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign wr_ready_o   = !full;
  assign level_o      = level_q;
  assign sample_out_o = sample_q;
  assign sample_we_o  = we_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_pdm_sample_feeder.sv
// Bench for pdm_sample_feeder: a hand-built vector table, directed corner
// sequences and a random run, all checked against a queue-based model that
// schedules ticks by absolute cycle number.
module tb_pdm_sample_feeder;

  localparam int DEPTH = 8;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [4:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic             enable;
  logic [DIV_W-1:0] div;
  logic             clr_underrun;
  logic [4:0]       sample_out;
  logic             sample_we;
  logic [3:0]       level;
  logic             underrun;

  pdm_sample_feeder #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .wr_data_i      (wr_data),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready),
    .enable_i       (enable),
    .div_i          (div),
    .clr_underrun_i (clr_underrun),
    .sample_out_o   (sample_out),
    .sample_we_o    (sample_we),
    .level_o        (level),
    .underrun_o     (underrun)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model state
  logic [4:0] mq[$];
  logic [4:0] m_out;
  logic       m_we;
  logic       m_und;
  int         cyc;
  int         m_next;

  typedef struct {
    logic       v;
    logic [4:0] d;
    logic       en;
    logic [7:0] dv;
    logic       clr;
    logic       e_we;
    logic [4:0] e_out;
    logic [3:0] e_lvl;
    logic       e_und;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out  = 5'h00;
    m_we   = 1'b0;
    m_und  = 1'b0;
    m_next = cyc;
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare.
  task automatic step(input logic v, input logic [4:0] d, input logic en,
                      input logic [7:0] dv, input logic clr);
    int sz;
    bit tk;
    wr_valid = v; wr_data = d; enable = en; div = dv; clr_underrun = clr;
    @(posedge clk);
    sz = mq.size();
    tk = en && (cyc == m_next);
    if (!en || tk) m_next = cyc + 1 + int'(dv);
    m_we = 1'b0;
    if (tk && sz > 0) begin
      m_out = mq.pop_front();
      m_we  = 1'b1;
    end
    if (tk && sz == 0) m_und = 1'b1;
    else if (clr)      m_und = 1'b0;
    if (v && sz < DEPTH) mq.push_back(d);
    cyc++;
    #1;
    chk("model_sample_out", 32'(sample_out), 32'(m_out));
    chk("model_sample_we",  32'(sample_we),  32'(m_we));
    chk("model_level",      32'(level),      32'(mq.size()));
    chk("model_wr_ready",   32'(wr_ready),   32'(mq.size() != DEPTH));
    chk("model_underrun",   32'(underrun),   32'(m_und));
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_data = 5'h00; enable = 1'b0; div = '0; clr_underrun = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_at[4];
    int found;
    int n;
    logic [7:0] rdiv;

    // Pacing sequence: push 1..4 disabled, then div=3 gives a pop every 4 cycles.
    tbl[0]  = '{1'b1, 5'h01, 1'b0, 8'd3, 1'b0, 1'b0, 5'h00, 4'd1, 1'b0};
    tbl[1]  = '{1'b1, 5'h02, 1'b0, 8'd3, 1'b0, 1'b0, 5'h00, 4'd2, 1'b0};
    tbl[2]  = '{1'b1, 5'h03, 1'b0, 8'd3, 1'b0, 1'b0, 5'h00, 4'd3, 1'b0};
    tbl[3]  = '{1'b1, 5'h04, 1'b0, 8'd3, 1'b0, 1'b0, 5'h00, 4'd4, 1'b0};
    tbl[4]  = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h00, 4'd4, 1'b0};
    tbl[5]  = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h00, 4'd4, 1'b0};
    tbl[6]  = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h00, 4'd4, 1'b0};
    tbl[7]  = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b1, 5'h01, 4'd3, 1'b0};
    tbl[8]  = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h01, 4'd3, 1'b0};
    tbl[9]  = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h01, 4'd3, 1'b0};
    tbl[10] = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h01, 4'd3, 1'b0};
    tbl[11] = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b1, 5'h02, 4'd2, 1'b0};
    tbl[12] = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h02, 4'd2, 1'b0};
    tbl[13] = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h02, 4'd2, 1'b0};
    tbl[14] = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h02, 4'd2, 1'b0};
    tbl[15] = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b1, 5'h03, 4'd1, 1'b0};
    tbl[16] = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h03, 4'd1, 1'b0};
    tbl[17] = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h03, 4'd1, 1'b0};
    tbl[18] = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h03, 4'd1, 1'b0};
    tbl[19] = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b1, 5'h04, 4'd0, 1'b0};
    tbl[20] = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h04, 4'd0, 1'b0};
    tbl[21] = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h04, 4'd0, 1'b0};
    tbl[22] = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h04, 4'd0, 1'b0};
    tbl[23] = '{1'b0, 5'h00, 1'b1, 8'd3, 1'b0, 1'b0, 5'h04, 4'd0, 1'b1};

    cyc = 0;
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    chk("reset_level",    32'(level),      32'd0);
    chk("reset_wr_ready", 32'(wr_ready),   32'd1);
    chk("reset_sample",   32'(sample_out), 32'd0);

    // Table-driven pacing vectors
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].en, tbl[i].dv, tbl[i].clr);
      chk($sformatf("tbl%0d_we", i),  32'(sample_we),  32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_out", i), 32'(sample_out), 32'(tbl[i].e_out));
      chk($sformatf("tbl%0d_lvl", i), 32'(level),      32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_und", i), 32'(underrun),   32'(tbl[i].e_und));
    end

    // Mid-stream asynchronous reset with level 3
    for (int i = 0; i < 3; i++) step(1'b1, 5'(5'h11 + i), 1'b0, 8'd0, 1'b0);
    chk("pre_reset_level", 32'(level), 32'd3);
    idle_inputs();
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_level",    32'(level),      32'd0);
    chk("async_reset_wr_ready", 32'(wr_ready),   32'd1);
    chk("async_reset_sample",   32'(sample_out), 32'd0);
    chk("async_reset_we",       32'(sample_we),  32'd0);
    chk("async_reset_underrun", 32'(underrun),   32'd0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Full and pointer wrap, three rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 9; i++) begin
        step(1'b1, 5'(5'h10 + i), 1'b0, 8'd0, 1'b0);
        if (i == 6) chk("fill_ready_before_full", 32'(wr_ready), 32'd1);
      end
      chk("full_level",    32'(level),    32'd8);
      chk("full_wr_ready", 32'(wr_ready), 32'd0);
      for (int i = 0; i < 8; i++) begin
        step(1'b0, 5'h00, 1'b1, 8'd0, 1'b0);
        chk("drain_we",     32'(sample_we),  32'd1);
        chk("drain_sample", 32'(sample_out), 32'(5'h10 + i));
      end
      chk("drain_empty", 32'(level), 32'd0);
      step(1'b0, 5'h00, 1'b0, 8'd0, 1'b0);
    end

    // Simultaneous push and pop at level 4
    for (int i = 0; i < 4; i++) step(1'b1, 5'(5'h0A + i), 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'($urandom), 1'b1, 8'd0, 1'b0);
      chk("pushpop_level", 32'(level),     32'd4);
      chk("pushpop_we",    32'(sample_we), 32'd1);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 5'h00, 1'b1, 8'd0, 1'b0);
    chk("pre_race_underrun", 32'(underrun), 32'd0);

    // Push into an empty FIFO on a tick
    step(1'b1, 5'h07, 1'b1, 8'd0, 1'b0);
    chk("race_underrun", 32'(underrun), 32'd1);
    chk("race_we",       32'(sample_we), 32'd0);
    step(1'b0, 5'h00, 1'b1, 8'd0, 1'b0);
    chk("race_next_we",     32'(sample_we),  32'd1);
    chk("race_next_sample", 32'(sample_out), 32'h07);
    step(1'b0, 5'h00, 1'b0, 8'd0, 1'b1);
    chk("clear_underrun", 32'(underrun), 32'd0);
    step(1'b0, 5'h00, 1'b1, 8'd0, 1'b1);
    chk("clear_vs_set_underrun", 32'(underrun), 32'd1);

    // Divider reprogramming 7 -> 2 mid-count
    for (int i = 0; i < 4; i++) step(1'b1, 5'(5'h1A + i), 1'b0, 8'd7, 1'b1);
    found = 0;
    for (int i = 0; i < 4; i++) we_at[i] = -1;
    n = 0;
    while (found < 4 && n < 40) begin
      n++;
      step(1'b0, 5'h00, 1'b1, (found >= 1 && n >= we_at[0] + 3) ? 8'd2 : 8'd7, 1'b0);
      if (sample_we) begin
        we_at[found] = n;
        found++;
      end
    end
    chk("reprog_first_period", 32'(we_at[0]),            32'd8);
    chk("reprog_old_period",   32'(we_at[1] - we_at[0]), 32'd8);
    chk("reprog_new_period1",  32'(we_at[2] - we_at[1]), 32'd3);
    chk("reprog_new_period2",  32'(we_at[3] - we_at[2]), 32'd3);

    // Enable held low with data present, then first tick after div+1 cycles
    for (int i = 0; i < 3; i++) step(1'b1, 5'(5'h05 + i), 1'b0, 8'd5, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 5'h00, 1'b0, 8'd5, 1'b0);
      chk("enable_low_no_we", 32'(sample_we), 32'd0);
    end
    found = -1;
    for (int i = 1; i <= 20 && found < 0; i++) begin
      step(1'b0, 5'h00, 1'b1, 8'd5, 1'b0);
      if (sample_we) found = i;
    end
    chk("enable_rise_first_tick", 32'(found), 32'd6);
    chk("enable_rise_sample",     32'(sample_out), 32'h05);

    // Random traffic against the model
    rdiv = 8'd1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) rdiv = 8'($urandom_range(0, 3));
      step(1'($urandom), 5'($urandom), ($urandom_range(0, 7) != 0), rdiv,
           ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
